// File: rtl/conf_int_mac_accum_seq.sv
// rtl/conf_int_mac_accum_seq.sv - operand sequencer and accumulator around a combinational integer MAC
// Optional saturation enabled by defining CONF_INT_MAC_ACCUM_SEQ_SAT_EN.
module conf_int_mac_accum_seq #(
   parameter int OP_BITWIDTH        = 16,
   parameter int DATA_PATH_BITWIDTH = 16,
   parameter int LEN_BITWIDTH       = 8
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            start,
   input  logic [LEN_BITWIDTH-1:0]         len,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic [DATA_PATH_BITWIDTH-1:0]   in_a,
   input  logic [DATA_PATH_BITWIDTH-1:0]   in_b,
   output logic [DATA_PATH_BITWIDTH-1:0]   mac_a,
   output logic [DATA_PATH_BITWIDTH-1:0]   mac_b,
   output logic [2*DATA_PATH_BITWIDTH-1:0] mac_c_in,
   input  logic [2*DATA_PATH_BITWIDTH-1:0] mac_d,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [2*DATA_PATH_BITWIDTH-1:0] out_d,
   output logic                            busy,
   output logic                            sat
);

   localparam int DW = DATA_PATH_BITWIDTH;
   localparam int AW = 2 * DATA_PATH_BITWIDTH;

   function automatic logic [DW-1:0] op_mask();
      logic [DW-1:0] m;
      for (int i = 0; i < DW; i++) begin
         m[i] = (i < OP_BITWIDTH);
      end
      return m;
   endfunction

   localparam logic [DW-1:0] OP_MASK = op_mask();

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t                  state;
   logic [AW-1:0]           acc;
   logic [AW-1:0]           acc_next;
   logic [LEN_BITWIDTH-1:0] cnt;
   logic                    sat_q;
   logic                    sat_next;

   assign mac_a    = in_a & OP_MASK;
   assign mac_b    = in_b & OP_MASK;
   assign mac_c_in = acc;
   assign out_d    = acc;

   assign in_ready  = (state == ACCUM);
   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);

`ifdef CONF_INT_MAC_ACCUM_SEQ_SAT_EN
   // A sum smaller than the running total means the MAC wrapped; clamp and stick.
   always_comb begin
      acc_next = mac_d;
      sat_next = sat_q;
      if (sat_q || (mac_d < acc)) begin
         acc_next = '1;
         sat_next = 1'b1;
      end
   end
`else
   always_comb begin
      acc_next = mac_d;
      sat_next = 1'b0;
   end
`endif

   assign sat = sat_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         acc   <= '0;
         cnt   <= '0;
         sat_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  acc   <= '0;
                  sat_q <= 1'b0;
                  cnt   <= len;
                  state <= (len == '0) ? DONE : ACCUM;
               end
            end
            ACCUM: begin
               if (in_valid) begin
                  acc   <= acc_next;
                  sat_q <= sat_next;
                  cnt   <= cnt - 1'b1;
                  if (cnt == LEN_BITWIDTH'(1)) begin
                     state <= DONE;
                  end
               end
            end
            DONE: begin
               if (out_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/conf_int_mac_accum_seq.md
# conf_int_mac_accum_seq

Sequencer and accumulator stage wrapped around the combinational integer MAC. It accepts a stream of operand pairs over a valid/ready handshake and drives the MAC's `a`/`b` inputs. It holds the running sum in a register fed back to the MAC's `c_in`, and captures the MAC's `d` output each accepted beat. After `len` beats it presents the final dot-product result downstream over a second valid/ready handshake.

## Interface
- `OP_BITWIDTH`, 16: effective operand width; operand bits at and above this position are zeroed before driving the MAC.
- `DATA_PATH_BITWIDTH`, 16: operand port width; the accumulator is 2*DATA_PATH_BITWIDTH wide.
- `LEN_BITWIDTH`, 8: width of the beat-count input.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin a new accumulation; sampled only in IDLE.
- `len`  in  LEN_BITWIDTH  number of operand pairs, latched with `start`.
- `in_valid`  in  1  operand pair valid.
- `in_ready`  out  1  block accepts an operand pair.
- `in_a`, `in_b`  in  DATA_PATH_BITWIDTH each  operands, unsigned.
- `mac_a`, `mac_b`  out  DATA_PATH_BITWIDTH each  to MAC `a`/`b` (masked operands).
- `mac_c_in`  out  2*DATA_PATH_BITWIDTH  to MAC `c_in`; always equals the accumulator register.
- `mac_d`  in  2*DATA_PATH_BITWIDTH  from MAC `d`, which is `a*b + c_in`, combinational.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts the result.
- `out_d`  out  2*DATA_PATH_BITWIDTH  final accumulated value; equals the accumulator.
- `busy`  out  1  high in any state other than IDLE.
- `sat`  out  1  sticky saturation flag; tied 0 unless the macro is defined.

## Operation
- States: IDLE, ACCUM, DONE.
- **IDLE**
  - `in_ready`=0, `out_valid`=0.
  - On `start`=1: accumulator cleared to 0, `sat` cleared, counter loaded with `len`.
  - `len`≠0 goes to ACCUM; `len`=0 goes directly to DONE with result 0.
- **ACCUM**
  - `in_ready`=1.
  - Beat = `in_valid`&&`in_ready`. On a beat, the accumulator loads `mac_d` and the counter decrements.
  - A beat with counter==1 goes to DONE. No beat means the state is held, with no change.
- **DONE**
  - `out_valid`=1.
  - When `out_valid`&&`out_ready`, go to IDLE. The accumulator keeps its value until the next `start`.
- Operand masking: `mac_a`=`in_a` & ((1<<OP_BITWIDTH)-1). `mac_b` is masked the same way.
- Arithmetic: unsigned, modulo 2^(2*DATA_PATH_BITWIDTH). Without the macro, wrap-around is silent.
- `start` outside IDLE is ignored; it does not restart an accumulation.
- `len` and `start` changes outside IDLE have no effect.
- Reset mid-operation: immediately returns to IDLE. In-flight beats are discarded; no partial result is output.

## Timing
- Reset values:
  - state IDLE, accumulator 0, counter 0.
  - `in_ready`=0, `out_valid`=0, `busy`=0, `sat`=0.
  - `out_d`=0, `mac_c_in`=0.
- `in_ready`, `out_valid` and `busy` are decoded from registered state only; there is no combinational path from `in_valid`/`out_ready`.
- `start` in cycle N:
  - ACCUM with `in_ready`=1 in cycle N+1.
  - For `len`=0, `out_valid`=1 in cycle N+1 instead.
- Last beat accepted in cycle M: `out_valid`=1 and `out_d` final in cycle M+1.
- Minimum turnaround: 1 cycle in DONE when `out_ready`=1, then 1 cycle in IDLE before the next `start` is accepted.
- Throughput: one beat per cycle. A `len`=L job with no stalls takes L+3 cycles, `start` to IDLE.
- `mac_a`, `mac_b` and `mac_c_in` are combinational on the operand inputs and register outputs. The MAC has no registers, so `mac_d` settles in the same cycle.

## Configuration
- `CONF_INT_MAC_ACCUM_SEQ_SAT_EN`, defined:
  - A beat where `mac_d` < accumulator (unsigned wrap) loads all-ones instead and sets `sat`.
  - Once saturated, the accumulator stays all-ones and `sat` stays 1 until the next `start` or `rst`.
- Not defined: the accumulator wraps modulo 2^(2*DATA_PATH_BITWIDTH) and `sat` is constant 0.

## Test plan
- `len`=3, beats (2,3),(4,5),(6,7) back to back, `out_ready`=1 -> `out_d`=68, `out_valid` high for one cycle exactly 1 cycle after the third beat, then IDLE.
- `len`=2, `in_valid` gapped by 3 idle cycles between beats (10,10),(1,1); `out_ready` held 0 for 4 cycles -> `out_d`=101 held stable with `out_valid`=1 until `out_ready`.
- `len`=0 `start` -> DONE next cycle, `out_d`=0, no `in_ready` pulse.
- OP_BITWIDTH=8, DATA_PATH_BITWIDTH=16, `len`=1, beat (0x0103,0x0002) -> `mac_a`=0x0003, `out_d`=6.
- `len`=4, `rst` asserted after 2 beats -> all outputs at reset values immediately; `start` with `len`=1, beat (5,5) afterward -> `out_d`=25.
- Macro defined, DATA_PATH_BITWIDTH=16, `len`=3, beats (0xFFFF,0xFFFF) x3 -> second beat wraps, so `out_d`=0xFFFFFFFF and `sat`=1. Macro undefined, same stimulus -> `out_d`=0xFFFA0003 and `sat`=0.
